// File: rtl/seq_gen_pkg.sv
// Shared types and default widths for the serial pattern transmitter.
// The PARITY state is used only when SEQ_GEN_PARITY_EN is defined.
package seq_gen_pkg;

   localparam int PAT_W_DEF = 4;
   localparam int CNT_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      PARITY = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Debug view: FSM state plus the current shift-register MSB.
   typedef struct packed {
      state_e state;
      logic   shreg_msb;
   } seq_dbg_t;

endpackage

// File: rtl/sequence_generator_piso.sv
// Parallel-in serial-out shift register (MSB first) with load priority over shift.
// nxt_msb_o exposes the MSB the register will hold after the coming edge.
module seq_piso #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] data_i,
   output logic         msb_o,
   output logic         nxt_msb_o
);

   logic [W-1:0] sh_q, sh_d;

   always_comb begin
      sh_d = sh_q;
      if (load_i) begin
         sh_d = data_i;
      end else if (shift_i) begin
         sh_d = {sh_q[W-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign msb_o     = sh_q[W-1];
   assign nxt_msb_o = sh_d[W-1];

endmodule

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, count times.
// Defining SEQ_GEN_PARITY_EN appends an even-parity bit after every repetition.
module sequence_generator
   import seq_gen_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [PAT_W-1:0] pattern,
   input  logic [CNT_W-1:0] count,
   output logic             out,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output seq_dbg_t         dbg_o
);

   localparam int BW = (PAT_W > 1) ? $clog2(PAT_W) : 1;

   state_e           state_q, state_d;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [CNT_W-1:0] rep_q, rep_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic             out_q, out_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
   logic             load, shift, sh_msb, nxt_msb;
   logic [PAT_W-1:0] load_data;

   // The first load takes the live input; every reload takes the latched copy.
   assign load_data = (state_q == IDLE) ? pattern : pat_q;

   seq_piso #(.W(PAT_W)) u_piso (
      .clk       (clk),
      .rst_n     (reset),
      .load_i    (load),
      .shift_i   (shift),
      .data_i    (load_data),
      .msb_o     (sh_msb),
      .nxt_msb_o (nxt_msb)
   );

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      rep_d   = rep_q;
      bit_d   = bit_q;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (count != '0) begin
                  state_d = SEND;
                  pat_d   = pattern;
                  rep_d   = count;
                  bit_d   = BW'(PAT_W - 1);
                  load    = 1'b1;
               end else begin
                  state_d = DONE;
               end
            end
         end
         SEND: begin
            if (bit_q == '0) begin
               bit_d = BW'(PAT_W - 1);
               load  = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
               state_d = PARITY;
`else
               if (rep_q == CNT_W'(1)) begin
                  state_d = DONE;
               end else begin
                  rep_d = rep_q - CNT_W'(1);
               end
`endif
            end else begin
               bit_d = bit_q - BW'(1);
               shift = 1'b1;
            end
         end
`ifdef SEQ_GEN_PARITY_EN
         PARITY: begin
            if (rep_q == CNT_W'(1)) begin
               state_d = DONE;
            end else begin
               rep_d   = rep_q - CNT_W'(1);
               state_d = SEND;
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      out_d   = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_d)
         SEND: begin
            out_d   = nxt_msb;
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
`ifdef SEQ_GEN_PARITY_EN
         PARITY: begin
            out_d   = ^pat_q;
            valid_d = 1'b1;
            busy_d  = 1'b1;
         end
`endif
         DONE:    done_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         pat_q   <= '0;
         rep_q   <= '0;
         bit_q   <= '0;
         out_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         rep_q   <= rep_d;
         bit_q   <= bit_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out             = out_q;
   assign valid           = valid_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign dbg_o.state     = state_q;
   assign dbg_o.shreg_msb = sh_msb;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: directed cases plus random transfers checked
// against a bit-queue model of the stream (honours SEQ_GEN_PARITY_EN).
module tb_sequence_generator;
   import seq_gen_pkg::*;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] pattern;
   logic [3:0] count;
   logic       out, valid, busy, done;
   seq_dbg_t   dbg;

   int n_checks = 0;
   int n_fail   = 0;
   logic [0:0] exp_q[$];

   sequence_generator dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .pattern (pattern),
      .count   (count),
      .out     (out),
      .valid   (valid),
      .busy    (busy),
      .done    (done),
      .dbg_o   (dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Model: count repetitions of the pattern MSB-first, optional parity bit each.
   task automatic build_model(input logic [3:0] p, input logic [3:0] c);
      exp_q.delete();
      for (int r = 0; r < int'(c); r++) begin
         for (int i = 3; i >= 0; i--) exp_q.push_back(p[i]);
`ifdef SEQ_GEN_PARITY_EN
         exp_q.push_back(^p);
`endif
      end
   endtask

   // disturb=1: inputs churn during the transfer and start pulses while busy/done.
   task automatic run_xfer(input logic [3:0] p, input logic [3:0] c, input bit disturb);
      int k;
      logic [0:0] b;
      @(negedge clk);
      pattern = p;
      count   = c;
      start   = 1'b1;
      build_model(p, c);
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (exp_q.size() > 0) begin
         b = exp_q.pop_front();
         check_eq("valid", valid, 1);
         check_eq("out", out, b);
         check_eq("busy", busy, 1);
         check_eq("done_early", done, 0);
         if (disturb) begin
            pattern = (k == 2) ? 4'b0111 : 4'($urandom);
            count   = 4'($urandom);
            start   = (k == 2) ? 1'b1 : 1'($urandom_range(0, 1));
         end
         k++;
         @(negedge clk);
      end
      check_eq("done_pulse", done, 1);
      check_eq("done_valid", valid, 0);
      check_eq("done_busy", busy, 0);
      check_eq("done_out", out, 0);
      start = disturb ? 1'b1 : 1'b0;
      @(negedge clk);
      start = 1'b0;
      check_eq("idle_done", done, 0);
      check_eq("idle_valid", valid, 0);
      check_eq("idle_busy", busy, 0);
   endtask

   task automatic run_reset_abort();
      @(negedge clk);
      pattern = 4'b1010;
      count   = 4'd2;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq("abort_c1_out", out, 1);
      @(negedge clk);
      check_eq("abort_c2_out", out, 0);
      @(posedge clk);
      #2;
      check_eq("abort_c3_out", out, 1);
      reset = 1'b0;
      #1;
      check_eq("abort_out", out, 0);
      check_eq("abort_valid", valid, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_done", done, 0);
      check_eq("abort_state", dbg.state, IDLE);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("abort_no_done", done, 0);
      end
      reset = 1'b1;
      run_xfer(4'b1010, 4'd2, 1'b0);
   endtask

   initial begin
      reset   = 1'b0;
      start   = 1'b0;
      pattern = '0;
      count   = '0;
      repeat (2) @(negedge clk);
      check_eq("rst_out", out, 0);
      check_eq("rst_valid", valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_state", dbg.state, IDLE);
      reset = 1'b1;
      @(negedge clk);
      check_eq("post_rst_idle", valid, 0);

      run_xfer(4'b1010, 4'd1, 1'b0);
      run_xfer(4'b1101, 4'd3, 1'b0);
      run_xfer(4'b1111, 4'd0, 1'b0);
      run_xfer(4'b1000, 4'd2, 1'b1);
      run_xfer(4'b1011, 4'd2, 1'b0);
      run_xfer(4'b0001, 4'd15, 1'b0);
      run_reset_abort();

      for (int i = 0; i < 25; i++) begin
         run_xfer(4'($urandom), 4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial pattern transmitter, the driving end of the serial bit-stream interface consumed by `sequence_detector`. It latches a PAT_W-bit pattern and a repetition count on a start pulse, then emits the pattern MSB-first on `out`, one bit per clock, for the requested number of repetitions. It serves as the stimulus source for detector testbenches and as the on-chip sender in the Lab 3 datapath.

## Interface
- PAT_W, default 4: pattern width in bits (≥2).
- CNT_W, default 4: width of the repetition count.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  single-cycle request; sampled only in IDLE.
- pattern  input  PAT_W  bit pattern; latched when start is accepted.
- count  input  CNT_W  number of repetitions; latched when start is accepted.
- out  output  1  serial data bit; 0 whenever valid=0.
- valid  output  1  out carries a transmitted bit this cycle.
- busy  output  1  transfer in progress (start is ignored).
- done  output  1  one-cycle pulse after the final bit.

## Operation
- FSM states: IDLE, SEND, (PARITY when the macro is defined), DONE.
- IDLE: busy=0. On start=1 with count≠0: latch pattern into the shift register, load rep_cnt=count, bit_cnt=PAT_W-1, go to SEND. With count=0: go directly to DONE and transmit nothing.
- SEND: out=shreg[PAT_W-1], valid=1, busy=1. Each cycle shift left and decrement bit_cnt. At bit_cnt=0, reload the shift register from the latched pattern copy, decrement rep_cnt, and set bit_cnt=PAT_W-1. When rep_cnt reaches 1 at bit_cnt=0, go to DONE (or to PARITY).
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start in DONE is ignored.
- A start while busy=1 is ignored. Latched values are unaffected by later changes on pattern or count.
- Counters are unsigned with no wrap. rep_cnt never underflows because count=0 is handled in IDLE.

## Timing
- Reset (async assert): out=0, valid=0, busy=0, done=0, state=IDLE, all counters 0. Deassertion is synchronized to clk by the existing reset convention.
- Reset asserted mid-transfer aborts immediately: outputs go to 0 in the same cycle and no done pulse is produced.
- Latency: start is accepted at edge N. The first bit (pattern MSB) is valid in cycle N+1.
- Bits stream back-to-back with no gaps: count×PAT_W consecutive valid cycles.
- done rises in the cycle after the last valid bit.
- The earliest next start is accepted in the cycle after done (IDLE).
- All outputs are registered.

## Configuration
- Macro: SEQ_GEN_PARITY_EN.
- Defined: after each repetition the FSM passes through PARITY for one cycle with valid=1 and out set to the even-parity bit (XOR of the pattern bits). A transfer then lasts count×(PAT_W+1) valid cycles. The repetition loop returns from PARITY to SEND. The last repetition goes from PARITY to DONE.
- Undefined: the PARITY state and its logic are absent, and the stream is count×PAT_W bits.

## Structure
- Package seq_gen_pkg holds:
  - the state enumeration (IDLE, SEND, PARITY, DONE);
  - default width constants PAT_W_DEF=4 and CNT_W_DEF=4.
- Sub-module seq_piso: PAT_W-bit parallel-in serial-out shift register with load, shift, and msb output. It also serves future senders.
- Top level contains the FSM, bit_cnt ($clog2(PAT_W) bits), rep_cnt (CNT_W bits), and output registers.

## Test plan
- Single repetition: pattern=4'b1010, count=1, start at cycle 0. Required: out=1,0,1,0 with valid=1 in cycles 1–4, done=1 in cycle 5, busy=0 from cycle 5.
- Repetition: pattern=4'b1101, count=3. Required: 12 contiguous valid bits 110111011101, then a single done pulse.
- Zero count: pattern=4'b1111, count=0. Required: valid never asserts, done=1 in cycle 1.
- Busy rejection: start with pattern=4'b1000, count=2, then pulse start with pattern=4'b0111 at cycle 3. Required: stream is 10001000 only, with one done pulse.
- Reset mid-transfer: pattern=4'b1010, count=2, drive reset=0 at cycle 3. Required: out, valid, busy, and done are 0 immediately, there is no done pulse, and a new start after reset=1 transmits normally.
- With SEQ_GEN_PARITY_EN defined: pattern=4'b1011, count=2. Required: out=1011 1 1011 1 over 10 valid cycles, then done.
